// File: rtl/mu_broadcast_arbiter_pkg.sv
// Shared types and constants for the motion-update broadcast arbiter.
package mu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        BROADCAST = 2'b01,
        DRAIN     = 2'b10,
        DONE      = 2'b11
    } mu_state_t;

    // Cache write-count cycle, buffer flip, one margin cycle.
    localparam int unsigned DRAIN_CYCLES     = 3;
    localparam int unsigned COORDS           = 3;
    localparam int unsigned BEAT_COUNT_WIDTH = 16;

    function automatic int unsigned particle_width(input int unsigned data_width);
        return COORDS * data_width;
    endfunction

    function automatic int unsigned dst_width(input int unsigned cell_id_width);
        return COORDS * cell_id_width;
    endfunction

endpackage

// File: rtl/mu_broadcast_arbiter_if.sv
// Requester/broadcast bus bundle for mu_broadcast_arbiter.
// beat_count exists only when MU_BEAT_COUNT_EN is defined.
interface mu_broadcast_arbiter_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CELL_ID_WIDTH = 4,
    parameter int unsigned NUM_REQ       = 4
);
    import mu_arb_pkg::*;

    localparam int unsigned PW   = particle_width(DATA_WIDTH);
    localparam int unsigned DSTW = dst_width(CELL_ID_WIDTH);

    logic                      start;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PW-1:0]     req_data;
    logic [NUM_REQ*DSTW-1:0]   req_dst_cell;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      motion_update_enable;
    logic [PW-1:0]             out_data;
    logic [DSTW-1:0]           out_data_dst_cell;
    logic                      out_data_valid;
    logic                      busy;
    logic                      done;
`ifdef MU_BEAT_COUNT_EN
    logic [BEAT_COUNT_WIDTH-1:0] beat_count;
`endif

    modport master (
        output start, req_valid, req_data, req_dst_cell, req_done,
        input  req_ready, motion_update_enable, out_data, out_data_dst_cell,
               out_data_valid, busy, done
`ifdef MU_BEAT_COUNT_EN
        , input beat_count
`endif
    );

    modport slave (
        input  start, req_valid, req_data, req_dst_cell, req_done,
        output req_ready, motion_update_enable, out_data, out_data_dst_cell,
               out_data_valid, busy, done
`ifdef MU_BEAT_COUNT_EN
        , output beat_count
`endif
    );

endinterface

// File: rtl/mu_broadcast_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter; pointer names the highest-priority index
// and moves to one past each granted requester.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        idx      = '0;
        found    = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/mu_broadcast_arbiter.sv
// Motion-update broadcast sequencer: arbitrates requesters onto the cache bus,
// drains, then pulses done. Optional beat counter under MU_BEAT_COUNT_EN.
module mu_broadcast_arbiter
    import mu_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CELL_ID_WIDTH = 4,
    parameter int unsigned NUM_REQ       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mu_broadcast_arbiter_if.slave bus
);
    localparam int unsigned PW   = particle_width(DATA_WIDTH);
    localparam int unsigned DSTW = dst_width(CELL_ID_WIDTH);

    mu_state_t          state;
    logic [NUM_REQ-1:0] done_latch;
    logic [1:0]         drain_cnt;
    logic [NUM_REQ-1:0] req_mask;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      sel_data;
    logic [DSTW-1:0]    sel_dst;
    logic               any_grant;
    logic               all_done;

    // Latched requesters are masked; a same-cycle req_done still wins its beat.
    assign req_mask  = (state == BROADCAST) ? (bus.req_valid & ~done_latch) : '0;
    assign any_grant = |grant;
    assign all_done  = &(done_latch | bus.req_done);
    assign bus.req_ready = grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (req_mask),
        .grant (grant)
    );

    always_comb begin
        sel_data = '0;
        sel_dst  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = bus.req_data[i*PW +: PW];
                sel_dst  = bus.req_dst_cell[i*DSTW +: DSTW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= IDLE;
            done_latch               <= '0;
            drain_cnt                <= '0;
            bus.motion_update_enable <= 1'b0;
            bus.out_data             <= '0;
            bus.out_data_dst_cell    <= '0;
            bus.out_data_valid       <= 1'b0;
            bus.busy                 <= 1'b0;
            bus.done                 <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    done_latch            <= '0;
                    drain_cnt             <= '0;
                    bus.out_data          <= '0;
                    bus.out_data_dst_cell <= '0;
                    bus.out_data_valid    <= 1'b0;
                    if (bus.start) begin
                        state                    <= BROADCAST;
                        bus.motion_update_enable <= 1'b1;
                        bus.busy                 <= 1'b1;
                    end
                end
                BROADCAST: begin
                    done_latch            <= done_latch | bus.req_done;
                    bus.out_data          <= sel_data;
                    bus.out_data_dst_cell <= sel_dst;
                    bus.out_data_valid    <= any_grant;
                    if (all_done && !any_grant) begin
                        state                    <= DRAIN;
                        drain_cnt                <= '0;
                        bus.motion_update_enable <= 1'b0;
                    end
                end
                DRAIN: begin
                    bus.out_data          <= '0;
                    bus.out_data_dst_cell <= '0;
                    bus.out_data_valid    <= 1'b0;
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MU_BEAT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.beat_count <= '0;
        end else if (state == IDLE && bus.start) begin
            bus.beat_count <= '0;
        end else if (bus.out_data_valid && bus.beat_count != '1) begin
            bus.beat_count <= bus.beat_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/mu_broadcast_arbiter.md
# mu_broadcast_arbiter

Sequencer and arbiter for the motion-update broadcast bus that feeds every position cache. It shares one broadcast bus among NUM_REQ motion-update units using round-robin arbitration. It drives the caches' motion_update_enable window. It signals completion only after every cache has written its particle count and flipped its active buffer.

## Interface
- DATA_WIDTH, 32: width of one coordinate; a particle is 3*DATA_WIDTH bits, {posz, posy, posx}.
- CELL_ID_WIDTH, 4: width of one cell coordinate; destination is {cell_x, cell_y, cell_z}.
- NUM_REQ, 4: number of motion-update requesters (2..16).
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a motion-update phase; ignored unless IDLE.
- req_valid  in  NUM_REQ  requester i holds a particle to broadcast.
- req_data  in  NUM_REQ*3*DATA_WIDTH  particle data; slice i belongs to requester i.
- req_dst_cell  in  NUM_REQ*3*CELL_ID_WIDTH  destination cell per requester.
- req_done  in  NUM_REQ  level or pulse: requester i has no further particles; latched internally.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- motion_update_enable  out  1  to every cache; high for the whole broadcast window.
- out_data  out  3*DATA_WIDTH  broadcast particle (cache in_data).
- out_data_dst_cell  out  3*CELL_ID_WIDTH  broadcast destination (cache in_data_dst_cell).
- out_data_valid  out  1  broadcast beat valid (cache in_data_valid).
- busy  out  1  high from the cycle after start until the cycle done pulses.
- done  out  1  one-cycle pulse when all caches have swapped buffers.

## Operation
- States: IDLE, BROADCAST, DRAIN, DONE.
- IDLE: all outputs low, done-latches cleared.
  - start moves to BROADCAST.
  - motion_update_enable rises in the same registered update.
- BROADCAST:
  - req_ready is combinational: one-hot to the highest-priority requester with req_valid high, rotating priority starting after the last granted index. Pointer resets to 0, so requester 0 has first priority.
  - A granted transfer registers out_data, out_data_dst_cell and out_data_valid=1 on the next edge. Cycles with no grant register out_data_valid=0 and zero data/dst.
  - Maximum of one transfer per cycle; back-to-back beats are allowed.
  - done_latch[i] sets on req_done[i]. A requester whose latch is set receives no further grant.
  - When every done_latch is set and no grant issues this cycle, go to DRAIN. The final out_data_valid beat is still presented while motion_update_enable is high.
- DRAIN: motion_update_enable=0, req_ready=0, out_data_valid=0. A 2-bit counter runs for 3 cycles, covering the cache write-count cycle, the buffer flip and one margin cycle; then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- A requester asserting req_valid and req_done together in the same cycle is still granted that beat. Its latch then blocks it afterwards.
- start outside IDLE is ignored. req_* inputs in IDLE are ignored.
- rst at any time forces IDLE and clears all outputs, latches, pointer and counter. A cache mid-phase sees motion_update_enable fall and finishes its own sequence.

## Timing
- Reset values: all outputs 0; state IDLE; pointer 0.
- start at cycle T: motion_update_enable=1 and busy=1 from T+1.
- Handshake at cycle T: out_data_valid=1 at T+1, always with motion_update_enable=1.
- Last grant at cycle T with all latches set: last beat at T+1, enable=0 from T+2, done pulses at T+5.
- No requesters active (all req_done high at T+1): enable high for exactly one cycle, done at T+5.

## Configuration
- MU_BEAT_COUNT_EN defined:
  - Adds output beat_count [15:0], the number of broadcast beats in the current phase.
  - Clears on start, increments on each out_data_valid, saturates at 16'hFFFF, and holds its value after done.
- MU_BEAT_COUNT_EN undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package mu_arb_pkg:
  - state encoding typedef (IDLE=2'b00, BROADCAST=2'b01, DRAIN=2'b10, DONE=2'b11);
  - DRAIN_CYCLES=3;
  - particle and destination-width helper constants derived from DATA_WIDTH and CELL_ID_WIDTH.
- Sub-module rr_arbiter holds the rotating pointer and one-hot grant logic, parameterized by NUM_REQ. Its request mask is req_valid & ~done_latch. The top level instantiates it once.

## Test plan
- Single requester, 3 particles to cell {3,2,3}: exactly 3 out_data_valid beats in order with correct dst; enable falls 1 cycle after the last beat; done 3 cycles later.
- All 4 requesters hold valid continuously: grants rotate 0,1,2,3,0,... with one beat per cycle and no requester starved.
- All req_done high on the first BROADCAST cycle: zero beats, enable high for 1 cycle, done at start+5.
- req_valid and req_done asserted together on requester 2: that beat is broadcast; no later grant to requester 2.
- rst asserted mid-BROADCAST: next cycle all outputs 0, state IDLE; a following start runs a clean phase with the pointer at 0.
- With MU_BEAT_COUNT_EN: 5 beats give beat_count=5 after done; a new start clears it to 0.
